memory_bus_arbiter: RTL and testbench
=====================================

MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, meaning the maximum number of granted cycles without bus_ready before an error completion; legal range 1..255.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  clock  in  1  single clock; all state updates on rising edge
  reset_n  in  1  synchronous active-low reset, sampled on rising edge of clock
  fetch_req  in  1  instruction fetch request; held until fetch_ack
  fetch_address  in  32  fetch word address; held stable while fetch_req
  fetch_read_data  out  32  fetch read data; valid only when fetch_ack
  fetch_ack  out  1  one-cycle fetch completion pulse
  data_req  in  1  data access request; held until data_ack
  data_write  in  1  1 = write, 0 = read; held stable while data_req
  data_address  in  32  data address; held stable
  data_write_data  in  32  pre-shifted write data; held stable
  data_byte_enable  in  4  byte lanes; held stable
  data_read_data  out  32  data read data; valid only when data_ack
  data_ack  out  1  one-cycle data completion pulse
  bus_error  out  1  high with an ack pulse when that access timed out
  bus_address  out  32  shared memory bus address
  bus_write_data  out  32  shared bus write data
  bus_byte_enable  out  4  shared bus byte enables
  bus_read_enable  out  1  shared bus read strobe
  bus_write_enable  out  1  shared bus write strobe
  bus_read_data  in  32  memory read data, valid with bus_ready
  bus_ready  in  1  memory completes the current access this cycle

Function
REQ-003 SHALL implement states IDLE, FETCH, DATA, held in a state register.
REQ-004 SHALL, in IDLE, drive bus_address=0, bus_write_data=0, bus_byte_enable=0, bus_read_enable=0, bus_write_enable=0, and both acks and bus_error low.
REQ-005 SHALL, in IDLE, go to FETCH if only fetch_req, DATA if only data_req, and stay IDLE if neither.
REQ-006 SHALL, in IDLE with both requests, grant the requester not granted most recently (last_grant register); last_grant SHALL be FETCH after reset, so DATA wins the first tie.
REQ-007 SHALL update last_grant on every IDLE->FETCH or IDLE->DATA transition.
REQ-008 SHALL, in FETCH, drive bus_address=fetch_address, bus_byte_enable=4'b1111, bus_read_enable=1, bus_write_enable=0, bus_write_data=0.
REQ-009 SHALL, in DATA, drive bus_address=data_address, bus_write_data=data_write_data, bus_byte_enable=data_byte_enable, bus_write_enable=data_write, bus_read_enable=~data_write.
REQ-010 SHALL drive the bus outputs combinationally from the state register and held requester inputs; they are not registered.
REQ-011 SHALL, in FETCH or DATA with bus_ready=1, assert the matching ack combinationally in that cycle, pass bus_read_data to the matching read_data output, and go to IDLE next cycle.
REQ-012 SHALL hold fetch_read_data and data_read_data at 0 whenever their ack is low.
REQ-013 SHALL always return to IDLE for at least one cycle between grants; minimum occupancy is grant cycle plus one IDLE cycle.
REQ-014 SHALL load an 8-bit wait counter with 0 on entry to FETCH or DATA and increment it each granted cycle without bus_ready.
REQ-015 SHALL, when the counter equals TIMEOUT_CYCLES-1 and bus_ready=0, assert the matching ack and bus_error for that cycle, force read data to 0, and go to IDLE.
REQ-016 SHALL give bus_ready priority over timeout in the same cycle: normal completion, bus_error=0.
REQ-017 SHALL ignore bus_ready and bus_read_data while in IDLE.
REQ-018 SHALL not abort a granted access if the requester drops its request early; the access runs to ack or timeout.

Reset
REQ-019 SHALL, when reset_n=0 at a rising edge, set state=IDLE, last_grant=FETCH, counter=0, so all outputs take the IDLE values of REQ-004 from the next cycle, including when reset hits mid-access.
REQ-020 SHALL not generate an ack for an access cut short by reset.

Verification
REQ-021 Fetch only: fetch_req=1, fetch_address=0x100, bus_ready=1 in cycle 2 -> cycle 1 IDLE, cycle 2 bus_address=0x100, bus_byte_enable=1111, fetch_ack=1, cycle 3 IDLE.
REQ-022 Tie: both requests from reset -> DATA granted first, FETCH granted after the idle cycle; repeated ties alternate.
REQ-023 Data write: data_address=0x203, data_byte_enable=1000, data_write_data=0xAB000000 -> bus_write_enable=1, bus_read_enable=0, fields passed unchanged.
REQ-024 Timeout: TIMEOUT_CYCLES=4, bus_ready=0 -> ack plus bus_error in the 4th granted cycle, read data 0; ready in the same cycle -> bus_error=0.
REQ-025 Reset during DATA wait -> no ack, IDLE outputs next cycle, DATA wins the next tie.
REQ-026 Ready while IDLE, or request dropped mid-grant -> no spurious ack; granted access completes normally.

Source files
------------

// File: rtl/memory_bus_arbiter.sv
// Two-requester (instruction fetch / data) arbiter onto a single memory bus.
// Alternates on ties, forces an idle cycle between grants, and times out stalled accesses.
module memory_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        fetch_req,
  input  logic [31:0] fetch_address,
  output logic [31:0] fetch_read_data,
  output logic        fetch_ack,
  input  logic        data_req,
  input  logic        data_write,
  input  logic [31:0] data_address,
  input  logic [31:0] data_write_data,
  input  logic [3:0]  data_byte_enable,
  output logic [31:0] data_read_data,
  output logic        data_ack,
  output logic        bus_error,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  output logic [3:0]  bus_byte_enable,
  output logic        bus_read_enable,
  output logic        bus_write_enable,
  input  logic [31:0] bus_read_data,
  input  logic        bus_ready
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             last_grant_data;
  logic [CNT_W-1:0] wait_count;
  logic             timeout_c;

  // Final permitted wait cycle with no ready from memory.
  assign timeout_c = (state != IDLE) && !bus_ready && (wait_count == LAST_WAIT);

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Fairness bookkeeping and wait counter; counter sits at 0 while idle,
  // which is the value each new grant starts from.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last_grant_data <= 1'b0;
      wait_count      <= '0;
    end else begin
      if (state == IDLE && state_next == FETCH) begin
        last_grant_data <= 1'b0;
      end else if (state == IDLE && state_next == DATA) begin
        last_grant_data <= 1'b1;
      end

      if (state == IDLE) begin
        wait_count <= '0;
      end else if (!bus_ready) begin
        wait_count <= wait_count + CNT_W'(1);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (fetch_req && data_req) begin
          state_next = last_grant_data ? FETCH : DATA;
        end else if (fetch_req) begin
          state_next = FETCH;
        end else if (data_req) begin
          state_next = DATA;
        end
      end
      FETCH, DATA: begin
        if (bus_ready || timeout_c) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus and completion outputs, decoded from the current grant
  always_comb begin
    bus_address      = '0;
    bus_write_data   = '0;
    bus_byte_enable  = '0;
    bus_read_enable  = 1'b0;
    bus_write_enable = 1'b0;
    fetch_ack        = 1'b0;
    fetch_read_data  = '0;
    data_ack         = 1'b0;
    data_read_data   = '0;
    bus_error        = 1'b0;
    unique case (state)
      FETCH: begin
        bus_address     = fetch_address;
        bus_byte_enable = 4'b1111;
        bus_read_enable = 1'b1;
        if (bus_ready) begin
          fetch_ack       = 1'b1;
          fetch_read_data = bus_read_data;
        end else if (timeout_c) begin
          fetch_ack = 1'b1;
          bus_error = 1'b1;
        end
      end
      DATA: begin
        bus_address      = data_address;
        bus_write_data   = data_write_data;
        bus_byte_enable  = data_byte_enable;
        bus_write_enable = data_write;
        bus_read_enable  = !data_write;
        if (bus_ready) begin
          data_ack       = 1'b1;
          data_read_data = bus_read_data;
        end else if (timeout_c) begin
          data_ack  = 1'b1;
          bus_error = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Bench for memory_bus_arbiter: directed scenarios with literal expectations,
// then randomized requesters, all cross-checked every cycle against a transaction model.
module tb_memory_bus_arbiter;

  localparam int unsigned TO = 4;

  logic        clock;
  logic        reset_n;
  logic        fetch_req;
  logic [31:0] fetch_address;
  logic [31:0] fetch_read_data;
  logic        fetch_ack;
  logic        data_req;
  logic        data_write;
  logic [31:0] data_address;
  logic [31:0] data_write_data;
  logic [3:0]  data_byte_enable;
  logic [31:0] data_read_data;
  logic        data_ack;
  logic        bus_error;
  logic [31:0] bus_address;
  logic [31:0] bus_write_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_read_enable;
  logic        bus_write_enable;
  logic [31:0] bus_read_data;
  logic        bus_ready;

  memory_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .fetch_req        (fetch_req),
    .fetch_address    (fetch_address),
    .fetch_read_data  (fetch_read_data),
    .fetch_ack        (fetch_ack),
    .data_req         (data_req),
    .data_write       (data_write),
    .data_address     (data_address),
    .data_write_data  (data_write_data),
    .data_byte_enable (data_byte_enable),
    .data_read_data   (data_read_data),
    .data_ack         (data_ack),
    .bus_error        (bus_error),
    .bus_address      (bus_address),
    .bus_write_data   (bus_write_data),
    .bus_byte_enable  (bus_byte_enable),
    .bus_read_enable  (bus_read_enable),
    .bus_write_enable (bus_write_enable),
    .bus_read_data    (bus_read_data),
    .bus_ready        (bus_ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Transaction model: who owns the bus (0 none, 1 fetch, 2 data), which
  // granted cycle this is (1-based), and who won most recently.
  int m_grant     = 0;
  int m_cyc       = 0;
  bit m_last_data = 1'b0;
  bit exp_fetch_ack = 1'b0;
  bit exp_data_ack  = 1'b0;

  logic [31:0] e_addr, e_wd, e_frd, e_drd;
  logic [3:0]  e_be;
  logic        e_re, e_we, e_err;

  // Every cycle: expected outputs from the current owner and held inputs.
  always @(negedge clock) begin
    e_addr = '0; e_wd = '0; e_be = '0; e_re = 1'b0; e_we = 1'b0;
    e_frd = '0; e_drd = '0; e_err = 1'b0;
    exp_fetch_ack = 1'b0;
    exp_data_ack  = 1'b0;
    if (m_grant == 1) begin
      e_addr = fetch_address; e_be = 4'hF; e_re = 1'b1;
      if (bus_ready) begin exp_fetch_ack = 1'b1; e_frd = bus_read_data; end
      else if (m_cyc == int'(TO)) begin exp_fetch_ack = 1'b1; e_err = 1'b1; end
    end else if (m_grant == 2) begin
      e_addr = data_address; e_wd = data_write_data; e_be = data_byte_enable;
      e_we = data_write; e_re = !data_write;
      if (bus_ready) begin exp_data_ack = 1'b1; e_drd = bus_read_data; end
      else if (m_cyc == int'(TO)) begin exp_data_ack = 1'b1; e_err = 1'b1; end
    end
    check("bus", 128'({bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable}),
          128'({e_addr, e_wd, e_be, e_re, e_we}));
    check("resp", 128'({fetch_ack, data_ack, bus_error, fetch_read_data, data_read_data}),
          128'({exp_fetch_ack, exp_data_ack, e_err, e_frd, e_drd}));
  end

  // Model advance at each rising edge.
  always @(posedge clock) begin
    int g;
    g = m_grant;
    if (!reset_n) begin
      m_grant     <= 0;
      m_cyc       <= 0;
      m_last_data <= 1'b0;
    end else if (g == 0) begin
      if (fetch_req && data_req) g = m_last_data ? 1 : 2;
      else if (fetch_req)        g = 1;
      else if (data_req)         g = 2;
      m_grant <= g;
      if (g != 0) begin
        m_cyc       <= 1;
        m_last_data <= (g == 2);
      end
    end else if (exp_fetch_ack || exp_data_ack) begin
      m_grant <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic look();
    @(negedge clock);
    #1;
  endtask

  bit f_active = 1'b0;
  bit d_active = 1'b0;

  initial begin
    reset_n = 1'b0; bus_ready = 1'b0; bus_read_data = '0;
    fetch_req = 1'b0; fetch_address = '0;
    data_req = 1'b0; data_write = 1'b0; data_address = '0;
    data_write_data = '0; data_byte_enable = '0;

    repeat (2) cyc();
    look();
    check("reset_idle", 128'({bus_address, bus_byte_enable, bus_read_enable, bus_write_enable, fetch_ack, data_ack, bus_error}), 128'(0));
    cyc(); reset_n = 1'b1;

    // Fetch only, ready on first granted cycle
    fetch_req = 1'b1; fetch_address = 32'h100;
    look(); check("fetch_c1_idle", 128'({bus_address, fetch_ack}), 128'(0));
    cyc(); bus_ready = 1'b1; bus_read_data = 32'hDEAD_BEEF;
    look(); check("fetch_c2", 128'({bus_address, bus_byte_enable, fetch_ack, fetch_read_data}), 128'({32'h100, 4'hF, 1'b1, 32'hDEAD_BEEF}));
    cyc(); fetch_req = 1'b0; bus_ready = 1'b0;
    look(); check("fetch_c3_idle", 128'({bus_read_enable, fetch_ack}), 128'(0));

    // Ties from reset: data, fetch, data
    cyc(); reset_n = 1'b0;
    cyc(); reset_n = 1'b1;
    data_req = 1'b1; data_address = 32'h40; data_byte_enable = 4'hF;
    fetch_req = 1'b1; fetch_address = 32'h80;
    look();
    cyc(); bus_ready = 1'b1; bus_read_data = 32'h1111_2222;
    look(); check("tie1_data", 128'({bus_address, data_ack, fetch_ack, data_read_data}), 128'({32'h40, 1'b1, 1'b0, 32'h1111_2222}));
    cyc(); data_req = 1'b0; bus_ready = 1'b0;
    look(); check("tie_gap_idle", 128'({bus_read_enable, bus_address}), 128'(0));
    cyc(); bus_ready = 1'b1;
    look(); check("tie1_fetch", 128'({bus_address, fetch_ack}), 128'({32'h80, 1'b1}));
    cyc(); bus_ready = 1'b0; data_req = 1'b1; data_address = 32'h44;
    look();
    cyc(); bus_ready = 1'b1;
    look(); check("tie2_data", 128'({bus_address, data_ack, fetch_ack}), 128'({32'h44, 1'b1, 1'b0}));
    cyc(); data_req = 1'b0; fetch_req = 1'b0; bus_ready = 1'b0;
    look();

    // Byte write passes fields unchanged
    cyc(); data_req = 1'b1; data_write = 1'b1; data_address = 32'h203;
    data_byte_enable = 4'b1000; data_write_data = 32'hAB00_0000;
    look();
    cyc(); bus_ready = 1'b1;
    look(); check("write_bus", 128'({bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable, data_ack}),
                  128'({32'h203, 32'hAB00_0000, 4'b1000, 1'b0, 1'b1, 1'b1}));
    cyc(); data_req = 1'b0; data_write = 1'b0; bus_ready = 1'b0;
    look();

    // Timeout on the 4th granted cycle, then ready exactly on that cycle
    cyc(); data_req = 1'b1; data_address = 32'h300; data_byte_enable = 4'hF; bus_read_data = 32'hCAFE_F00D;
    look();
    for (int i = 0; i < 3; i++) begin
      cyc(); look(); check("timeout_wait", 128'({data_ack, bus_error}), 128'(0));
    end
    cyc(); look();
    check("timeout_err", 128'({data_ack, bus_error, data_read_data}), 128'({1'b1, 1'b1, 32'h0}));
    cyc(); look(); check("timeout_gap", 128'({bus_read_enable, data_ack}), 128'(0));
    for (int i = 0; i < 3; i++) begin
      cyc(); look();
    end
    cyc(); bus_ready = 1'b1;
    look(); check("ready_beats_timeout", 128'({data_ack, bus_error, data_read_data}), 128'({1'b1, 1'b0, 32'hCAFE_F00D}));
    cyc(); data_req = 1'b0; bus_ready = 1'b0;
    look();

    // Reset mid-wait: no ack, idle next cycle, data wins following tie
    cyc(); data_req = 1'b1; data_address = 32'h500;
    look();
    cyc(); look(); check("rst_pre_grant", 128'({bus_address, data_ack}), 128'({32'h500, 1'b0}));
    cyc(); reset_n = 1'b0;
    look(); check("rst_cycle_noack", 128'({data_ack, fetch_ack, bus_error}), 128'(0));
    cyc(); reset_n = 1'b1; fetch_req = 1'b1; fetch_address = 32'h600;
    look(); check("rst_idle", 128'({bus_address, bus_byte_enable, bus_read_enable, data_ack, fetch_ack}), 128'(0));
    cyc(); bus_ready = 1'b1;
    look(); check("rst_data_wins", 128'({bus_address, data_ack}), 128'({32'h500, 1'b1}));
    cyc(); data_req = 1'b0; bus_ready = 1'b0;
    look();
    cyc(); bus_ready = 1'b1;
    look(); check("rst_fetch_after", 128'({bus_address, fetch_ack}), 128'({32'h600, 1'b1}));
    cyc(); fetch_req = 1'b0; bus_ready = 1'b0;

    // Ready while idle, then request dropped mid-grant
    bus_ready = 1'b1; bus_read_data = 32'h5555_AAAA;
    look(); check("idle_ready_noack", 128'({fetch_ack, data_ack, fetch_read_data, data_read_data}), 128'(0));
    cyc(); bus_ready = 1'b0; fetch_req = 1'b1; fetch_address = 32'h700;
    look();
    cyc(); look();
    cyc(); fetch_req = 1'b0;
    look(); check("drop_still_granted", 128'({bus_address, fetch_ack}), 128'({32'h700, 1'b0}));
    cyc(); bus_ready = 1'b1; bus_read_data = 32'h77;
    look(); check("drop_completes", 128'({fetch_ack, bus_error, fetch_read_data}), 128'({1'b1, 1'b0, 32'h77}));
    cyc(); bus_ready = 1'b0;
    look();

    // Randomized requesters following the hold-until-ack protocol
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (exp_fetch_ack || (!reset_n && !fetch_req)) begin f_active = 1'b0; fetch_req = 1'b0; end
      if (exp_data_ack  || (!reset_n && !data_req))  begin d_active = 1'b0; data_req  = 1'b0; end
      reset_n = !((m_grant == 0 || m_cyc < int'(TO)) && $urandom_range(0, 99) < 2);
      bus_ready = reset_n && ($urandom_range(0, 99) < 35);
      bus_read_data = $urandom;
      if (!f_active) begin
        if ($urandom_range(0, 2) == 0) begin
          f_active = 1'b1; fetch_req = 1'b1; fetch_address = $urandom;
        end
      end else if (fetch_req && m_grant == 1 && $urandom_range(0, 7) == 0) begin
        fetch_req = 1'b0;
      end
      if (!d_active) begin
        if ($urandom_range(0, 2) == 0) begin
          d_active = 1'b1; data_req = 1'b1; data_write = 1'($urandom_range(0, 1));
          data_address = $urandom; data_write_data = $urandom;
          data_byte_enable = 4'($urandom_range(0, 15));
        end
      end else if (data_req && m_grant == 2 && $urandom_range(0, 7) == 0) begin
        data_req = 1'b0;
      end
    end

    cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
